// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

    // Clear-engine states.
    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

endpackage

// File: rtl/rf_clr_fsm.sv
// Sequential clear engine: walks the register index from 0 to NREGS-1,
// zeroing one register per cycle, then pulses clr_done for one cycle.
// The current state is visible on the state output for debug.
module rf_clr_fsm
    import rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_start,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output rf_state_e     state
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                // The last index moves on to DONE; the increment wraps to 0
                // at the same time, which is harmless.
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RF_DONE;
                end
            end
            RF_DONE: begin
                state_d = RF_IDLE;
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
        busy_d = (state_d != RF_IDLE);
        done_d = (state_d == RF_DONE);
    end

    // State, counter and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy  = busy_q;
    assign clr_done  = done_q;
    assign clr_start = (state_q == RF_IDLE) && clr_req;
    assign clr_en    = (state_q == RF_CLEAR);
    assign clr_addr  = cnt_q;
    assign state     = state_q;

endmodule

// File: rtl/rf_mp.sv
// Multi-read-port register file with hardwired zero register, same-cycle
// write bypass, pending-write scoreboard and a sequential clear engine.
module rf_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_pend,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              pend_en,
    input  logic [AW-1:0]     pend_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic          clr_start;
    logic          clr_en;
    logic [AW-1:0] clr_addr;
    rf_state_e     clr_state;
    logic          idle;
    logic          wr_ok;
    logic          pend_ok;

    rf_clr_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_fsm (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_start (clr_start),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .state     (clr_state)
    );

    // Writes and scoreboard sets are only honoured while the clear engine is idle.
    assign idle    = (clr_state == RF_IDLE);
    assign wr_ok   = wr_en   && idle && (wr_addr   != '0);
    assign pend_ok = pend_en && idle && (pend_addr != '0);

    // Next array and scoreboard contents; the global pend clear wins over everything.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (pend_ok) begin
            pend_d[pend_addr] = 1'b1;
        end
        if (clr_start) begin
            pend_d = '0;
        end
    end

    // Array and scoreboard storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Combinational read ports with zero register and write bypass.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] raddr;
        logic          nz;
        assign raddr = rd_addr[i*AW +: AW];
        assign nz    = (raddr != '0);
        assign rd_data[i*XLEN +: XLEN] = !nz ? '0 :
                                         (wr_ok && (wr_addr == raddr)) ? wr_data :
                                         mem_q[raddr];
        assign rd_pend[i] = nz && pend_q[raddr];
    end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the register file.
module tb_rf_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pend;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                pend_en;
    logic [AW-1:0]       pend_addr;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;

    int total  = 0;
    int passed = 0;

    // Behavioural model: register contents, pending flags, clear progress.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    bit              m_busy;
    int              m_t;

    always #5 clk = ~clk;

    rf_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pend   (rd_pend),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_en   (pend_en),
        .pend_addr (pend_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_t    = 0;
    endtask

    task automatic drive(input logic we, input int wa, input logic [XLEN-1:0] wd,
                         input logic pe, input int pa, input logic cr,
                         input int a0, input int a1);
        wr_en     = we;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        pend_en   = pe;
        pend_addr = AW'(pa);
        clr_req   = cr;
        rd_addr   = {AW'(a1), AW'(a0)};
    endtask

    // Compare every output with what the model says for the current inputs.
    task automatic check_outputs(input string tag);
        int              a;
        logic [XLEN-1:0] exp_d;
        logic            exp_p;
        #1;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            if (a == 0) exp_d = '0;
            else if (wr_en && !m_busy && int'(wr_addr) == a) exp_d = wr_data;
            else exp_d = m_regs[a];
            exp_p = (a != 0) && m_pend[a];
            chk($sformatf("%s_data%0d", tag, i), rd_data[i*XLEN +: XLEN], exp_d);
            chk($sformatf("%s_pend%0d", tag, i), XLEN'(rd_pend[i]), XLEN'(exp_p));
        end
        chk({tag, "_busy"}, XLEN'(clr_busy), XLEN'(m_busy));
        chk({tag, "_done"}, XLEN'(clr_done), XLEN'(m_busy && m_t == NREGS));
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic tick();
        if (!m_busy) begin
            if (wr_en && wr_addr != '0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (pend_en && pend_addr != '0) m_pend[pend_addr] = 1'b1;
            if (clr_req) begin
                for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t <= NREGS) m_regs[m_t-1] = '0;
            if (m_t == NREGS + 1) m_busy = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_all(input string tag, input bit expect_zero);
        for (int a = 0; a < NREGS; a += 2) begin
            drive(1'b0, 0, '0, 1'b0, 0, 1'b0, a, a + 1);
            check_outputs(tag);
            if (expect_zero) begin
                chk({tag, "_zero0"}, rd_data[XLEN-1:0], '0);
                chk({tag, "_zero1"}, rd_data[2*XLEN-1:XLEN], '0);
            end
        end
    endtask

    initial begin
        int busy_n;
        int done_n;
        int wa;

        reset = 1'b0;
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 3, 9);
        m_reset();
        #2;
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b1;

        // Write then read through the array; reg 31 is still zero.
        drive(1'b1, 7, 32'hAAAAAAAA, 1'b0, 0, 1'b0, 0, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 7, 31);
        check_outputs("rd7");
        chk("rd7_p0", rd_data[XLEN-1:0], 32'hAAAAAAAA);
        chk("rd31_p1", rd_data[2*XLEN-1:XLEN], 32'h0);

        // Same-cycle bypass.
        drive(1'b1, 6, 32'h0000FFFF, 1'b0, 0, 1'b0, 7, 6);
        check_outputs("byp");
        chk("byp_p1", rd_data[2*XLEN-1:XLEN], 32'h0000FFFF);
        tick();

        // Register 0 stays zero.
        drive(1'b1, 0, 32'h111105FA, 1'b0, 0, 1'b0, 0, 0);
        check_outputs("z0a");
        chk("z0_same", rd_data, '0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 0);
        check_outputs("z0b");
        chk("z0_after", rd_data, '0);

        // Scoreboard set, clear by write, set+write collision.
        drive(1'b0, 0, '0, 1'b1, 5, 1'b0, 5, 5);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 5, 5);
        check_outputs("pset");
        chk("pset_bits", XLEN'(rd_pend), 32'd3);
        drive(1'b1, 5, 32'h00001234, 1'b0, 0, 1'b0, 5, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 5, 5);
        check_outputs("pclr");
        chk("pclr_bits", XLEN'(rd_pend), 32'd0);
        drive(1'b1, 5, 32'h00005555, 1'b1, 5, 1'b0, 5, 5);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 5, 5);
        check_outputs("pboth");
        chk("pboth_bits", XLEN'(rd_pend), 32'd3);

        // Fill regs 1..31 and run a full clear with writes attempted while busy.
        for (int r = 1; r < NREGS; r++) begin
            drive(1'b1, r, 32'hC0DE0000 + 32'(r), 1'b1, r, 1'b0, 0, 0);
            tick();
        end
        drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 4, 31);
        check_outputs("creq");
        tick();
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            wa = int'($urandom_range(0, NREGS - 1));
            drive(m_busy, wa, $urandom, m_busy, int'($urandom_range(0, NREGS - 1)),
                  m_busy && ($urandom_range(0, 3) == 0), wa, int'($urandom_range(0, NREGS - 1)));
            check_outputs("clr");
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            tick();
        end
        chk("busy_len", XLEN'(busy_n), 32'd33);
        chk("done_pulses", XLEN'(done_n), 32'd1);
        read_all("clr_all", 1'b1);

        // Reset in the middle of a clear, with the counter at 10.
        for (int r = 1; r < NREGS; r++) begin
            drive(1'b1, r, 32'h5A000000 + 32'(r), 1'b0, 0, 1'b0, 0, 0);
            tick();
        end
        drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 12, 20);
            tick();
        end
        #2;
        reset = 1'b0;
        m_reset();
        check_outputs("mrst");
        chk("mrst_busy", XLEN'(clr_busy), 32'd0);
        read_all("mrst_all", 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 7, 32'h11111111, 1'b0, 0, 1'b0, 0, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 7, 8);
        check_outputs("mrst_w7");
        chk("mrst_w7_p0", rd_data[XLEN-1:0], 32'h11111111);

        // Random traffic, including occasional clears.
        for (int c = 0; c < 300; c++) begin
            wa = int'($urandom_range(0, NREGS - 1));
            drive($urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, NREGS - 1)),
                  $urandom_range(0, 40) == 0,
                  ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREGS - 1)),
                  ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREGS - 1)));
            check_outputs("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-read-port register file for the CPU datapath, the next generation of the single-write/dual-read `rf`. It adds a configurable read-port count, a hardwired zero register, same-cycle write-to-read bypass, a pending-write scoreboard for hazard detection, and a sequential clear engine that zeroes the array without a global reset. It sits between decode (read addresses, scoreboard set) and writeback (write port).

## Interface
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: register count, power of two, minimum 2.
- `NRD`, 2: number of read ports, 1..4.
- `AW`, `$clog2(NREGS)`: address width (derived, not overridden).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NRD*AW  read addresses, port i at `[i*AW +: AW]`.
- `rd_data`  out  NRD*XLEN  read data, port i at `[i*XLEN +: XLEN]`.
- `rd_pend`  out  NRD  scoreboard bit of each read address.
- `wr_en`  in  1  write enable.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  XLEN  write data.
- `pend_en`  in  1  mark a register as awaiting a write.
- `pend_addr`  in  AW  register to mark.
- `clr_req`  in  1  request a sequential clear of the array.
- `clr_busy`  out  1  clear engine active; writes and pend sets are dropped.
- `clr_done`  out  1  one-cycle pulse when the clear completes.

## Operation
- Reset (`reset`=0, asynchronous): all registers 0, all pend bits 0, FSM IDLE, counter 0. Outputs: `rd_data`=0, `rd_pend`=0, `clr_busy`=0, `clr_done`=0.
- Read is combinational. Address 0 always returns 0 and pend 0.
- Bypass: if `wr_en` is high, `clr_busy` is low, `wr_addr`==`rd_addr[i]` and the address is nonzero, then `rd_data[i]`=`wr_data` in the same cycle.
- Write: on a rising edge with `wr_en`, not busy, and `wr_addr`≠0, the register takes `wr_data` and its pend bit clears. Writes to address 0 are discarded.
- Scoreboard: on a rising edge with `pend_en`, not busy, and `pend_addr`≠0, the pend bit sets. A set and a write clear to the same address on the same edge leave the bit set.
- FSM states:
  - IDLE: `clr_req` at an edge leads to CLEAR, counter=0, all pend bits cleared.
  - CLEAR: each edge zeroes register[counter] and increments the counter. At counter==NREGS-1 the FSM goes to DONE.
  - DONE: `clr_done`=1 for this one cycle, then IDLE.
- `clr_busy`=1 in CLEAR and DONE. `clr_req` is ignored while busy.
- During CLEAR, reads return the partially cleared array and no bypass applies.

## Timing
- Write to read latency: 0 cycles via bypass, or 1 edge through the array.
- If `clr_req` is accepted at edge T, `clr_busy` rises after T. Register k is zero after edge T+1+k. `clr_done` is high in the cycle after edge T+NREGS. The FSM is back in IDLE after edge T+NREGS+1, so `clr_busy` stays high for NREGS+1 cycles.
- A `wr_en` in the same cycle `clr_req` is accepted (IDLE) is performed. Its pend clear is superseded by the global pend clear.
- The counter is AW bits wide, and the transition is taken before it wraps.
- Reset asserted mid-clear returns everything to reset values immediately.

## Structure
- Package `rf_pkg`: FSM state enum (`RF_IDLE`, `RF_CLEAR`, `RF_DONE`) and the default `XLEN`/`NREGS` constants.
- Sub-module `rf_clr_fsm`: state register, counter, `clr_busy`/`clr_done`, and the per-cycle clear address and enable.
- The array, scoreboard and read muxes stay in `rf_mp` under a generate loop over NRD.

## Test plan
- Write 0xAAAAAAAA to reg 7, then the next cycle read port0=7 and port1=31 -> port0 returns 0xAAAAAAAA, port1 returns 0.
- With `wr_en`, addr 6, 0x0000FFFF and `rd_addr[1]`=6 in the same cycle -> `rd_data[1]`=0x0000FFFF before the edge (bypass).
- Write 0x111105FA to reg 0 -> reading reg 0 returns 0 on every port, both in the same cycle and after the edge.
- `pend_en` on reg 5 -> `rd_pend`=1 for reads of 5. A write to 5 clears it. A set and a write to 5 on the same edge leave `rd_pend`=1.
- Regs 1..31 loaded with nonzero values, `clr_req` pulsed -> `clr_busy` high for 33 cycles, `clr_done` a single pulse, all regs read 0, writes during busy are dropped.
- Assert `reset` low mid-clear at counter 10 -> `clr_busy`=0, all data 0, and a following write of 0x11111111 to reg 7 reads back correctly.
